// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   fetch_state_t : controller FSM state
//   fetch_entry_t : one queued fetch result {pc, instr}
//   pc_legal()    : word aligned and inside a 2**pw byte program memory
package fetch_pkg;
  localparam int FETCH_DEPTH = 2;
  localparam int INSTR_W     = 32;
  localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, FAULT} fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // 33-bit compare so that a 32-bit program memory still has a valid limit.
  function automatic logic pc_legal(input logic [31:0] pc, input int unsigned pw);
    logic [32:0] lim;
    lim = (33'd1 << pw) - 33'd4;
    return (pc[1:0] == 2'b00) && ({1'b0, pc} <= lim);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Depth-2 fetch queue. Slot 0 is always the head; a pop shifts slot 1 down.
//   clk, rst    : clock, synchronous active-high reset (empties the queue)
//   push/entry  : write one entry (caller guarantees space, or a same-cycle pop)
//   pop         : drop the head (caller guarantees count != 0)
//   flush       : empty the queue; wins over push and pop
//   count, head : occupancy and head entry; full when count == FETCH_DEPTH
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head,
  output logic             full
);
  fetch_entry_t     ent_q [FETCH_DEPTH];
  fetch_entry_t     ent_d [FETCH_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wr_idx;

  // With a coincident pop the new entry lands one slot lower, which is what
  // allows push and pop together while full.
  assign wr_idx = count_q - CNT_W'(pop);

  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < FETCH_DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
      end
      if (push && (wr_idx < CNT_W'(FETCH_DEPTH))) ent_d[wr_idx] = push_entry;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Payload needs no reset: it is only looked at while count != 0.
  always_ff @(posedge clk) ent_q <= ent_d;

  assign count = count_q;
  assign head  = ent_q[0];
  assign full  = (count_q == CNT_W'(FETCH_DEPTH));
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks pc through a combinational program
// memory, queues {pc, instr} in a 2-entry FIFO and halts on an illegal pc.
//   clk, rst                    : clock, synchronous active-high reset
//   mem_addr / mem_instr        : program memory address and same-cycle data
//   redirect_valid/redirect_pc  : restart fetch at a new pc (flushes queue)
//   out_valid/out_ready         : head handshake; out_instr/out_pc head entry
//   fault / fault_pc            : halted on a bad pc, and that pc
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned PROG_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        mem_addr,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic               fault,
  output logic [31:0]        fault_pc
);
  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      fault_pc_q, fault_pc_d;
  logic             fault_q, fault_d;
  logic             skip_q, skip_d;
  logic             push, pop, full;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head, push_entry;

  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready && !redirect_valid;
  assign push_entry = '{pc: pc_q, instr: mem_instr};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    fault_d    = fault_q;
    skip_d     = 1'b0;
    push       = 1'b0;
    if (redirect_valid) begin
      if (pc_legal(redirect_pc, PROG_WIDTH)) begin
        pc_d    = redirect_pc;
        fault_d = 1'b0;
        state_d = FETCH;
        // One dead fetch cycle after a redirect, matching the reset-release
        // latency (first valid two edges later).
        skip_d  = 1'b1;
      end else begin
        fault_pc_d = redirect_pc;
        fault_d    = 1'b1;
        state_d    = FAULT;
      end
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else if (!pc_legal(pc_q, PROG_WIDTH)) begin
            fault_pc_d = pc_q;
            fault_d    = 1'b1;
            state_d    = FAULT;
          end else if (!full || pop) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        FAULT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
      fault_q    <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      fault_q    <= fault_d;
      skip_q     <= skip_d;
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head),
    .full       (full)
  );

  assign mem_addr  = pc_q;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PROG_WIDTH, default 10, giving the log2 byte size of the program memory it drives.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_addr, output, 32 bits: byte address presented to program memory.
REQ-006 SHALL have port mem_instr, input, 32 bits: instruction word returned combinationally for mem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1 bit: request to restart fetch at a new PC.
REQ-008 SHALL have port redirect_pc, input, 32 bits: the new PC, sampled when redirect_valid=1.
REQ-009 SHALL have port out_valid, output, 1 bit: the instruction at the queue head is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-011 SHALL have port out_instr, output, 32 bits: instruction word at the queue head.
REQ-012 SHALL have port out_pc, output, 32 bits: PC of out_instr.
REQ-013 SHALL have port fault, output, 1 bit: fetch halted on a bad PC.
REQ-014 SHALL have port fault_pc, output, 32 bits: the offending PC.

Function
REQ-015 SHALL implement states IDLE, FETCH and FAULT.
REQ-016 SHALL transition IDLE->FETCH unconditionally after one cycle.
REQ-017 SHALL hold fetch pointer pc; mem_addr SHALL equal pc in every state.
REQ-018 SHALL treat a PC as legal only if pc[1:0]==0 and pc <= 2**PROG_WIDTH-4.
REQ-019 SHALL buffer fetched instructions in a 2-entry FIFO of {pc, instr}; out_valid=(count!=0); out_instr and out_pc SHALL be the head entry.
REQ-020 SHALL pop the head when out_valid && out_ready && !redirect_valid.
REQ-021 SHALL, in FETCH with no redirect and pc legal, push {pc, mem_instr} and advance pc by 4 when count<2, or when count==2 and a pop occurs in the same cycle.
REQ-022 SHALL leave pc and count unchanged when count==2 and no pop occurs; this is a stall, not an error.
REQ-023 SHALL, in FETCH with no redirect and pc illegal (including sequential run-off past the top), push nothing, latch fault_pc<=pc and enter FAULT.
REQ-024 SHALL let already-queued entries drain normally while in FAULT.
REQ-025 SHALL give redirect_valid priority over push and pop in every state: flush the FIFO (count<=0); the coincident handshake is discarded by both sides.
REQ-026 SHALL, on a redirect with a legal redirect_pc, load pc<=redirect_pc, clear fault and go to FETCH.
REQ-027 SHALL, on a redirect with an illegal redirect_pc, load fault_pc<=redirect_pc, set fault and go to FAULT.
REQ-028 SHALL otherwise leave FAULT only through rst.
REQ-029 SHALL set fault=1 exactly while in FAULT.
REQ-030 SHALL assert out_valid 2 cycles after a legal redirect, i.e. at the second rising edge after the redirect edge.
REQ-031 SHALL sustain one instruction per cycle when out_ready is held at 1.
REQ-032 SHALL perform pc arithmetic modulo 2**32; wrap-around is caught by the legality check.

Reset
REQ-033 SHALL, while rst=1 at a rising edge, set state=IDLE, pc=RESET_PC, count=0, out_valid=0, fault=0, fault_pc=0; rst SHALL override redirect and all handshakes.
REQ-034 SHALL abort any operation in progress on reset mid-operation, with no residual queued entries.
REQ-035 SHALL assert the first out_valid at the second rising edge after rst deasserts, given a legal RESET_PC.
REQ-036 SHALL drive out_instr and out_pc as don't-care while out_valid=0.

Structure
REQ-037 SHALL take from shared package fetch_pkg: state enum fetch_state_t {IDLE, FETCH, FAULT}, constants FETCH_DEPTH=2 and INSTR_W=32, and entry struct fetch_entry_t {pc, instr}.
REQ-038 SHALL place the FIFO in sub-module fetch_fifo: depth-2, with push, pop, flush, count and head outputs, and simultaneous push and pop allowed when full.
REQ-039 SHALL keep FSM and pc logic in fetch_ctrl; the block SHALL be synthesizable with no latches.

Verification
REQ-040 SHALL cover reset release, RESET_PC=0, out_ready=1, with memory holding words A0..A3 at 0,4,8,12 -> out_valid at edge 2; out_pc 0,4,8,12 on consecutive cycles with matching instructions.
REQ-041 SHALL cover out_ready=0 for 5 cycles -> count saturates at 2, pc stops at 8, mem_addr stays 8; releasing ready gives PCs 0,4,8 in order.
REQ-042 SHALL cover a redirect to 0x40 coinciding with a handshake -> popped entry discarded, out_valid=0 next cycle, next out_pc=0x40 two cycles later.
REQ-043 SHALL cover a redirect to 0x42 -> fault=1, fault_pc=0x42, no pushes; a later redirect to 0x10 clears fault and resumes at 0x10.
REQ-044 SHALL cover PROG_WIDTH=10 with fetch running to 0x3FC -> the 0x3FC entry delivered, then fault=1 and fault_pc=0x400.
REQ-045 SHALL cover rst asserted while full and in FAULT -> next cycle out_valid=0, fault=0, state IDLE, pc=RESET_PC.
